// File: rtl/user_input_pkg.sv
// Button indices, arbitration priority and button-to-event mapping for the
// player input front end.
`include "defs.vh"

package user_input_pkg;

  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_ROTATE = 3;
  localparam int unsigned BTN_ENTER  = 4;
  localparam int unsigned BTN_CNT    = 5;

  typedef logic [2:0] ev_code_t;

  // Highest priority first.
  localparam int unsigned PRIO_ORDER [BTN_CNT] = '{BTN_ENTER, BTN_ROTATE, BTN_DOWN,
                                                   BTN_LEFT, BTN_RIGHT};

  function automatic ev_code_t btn_to_ev(input int unsigned idx);
    case (idx)
      BTN_LEFT:   return `EV_LEFT;
      BTN_RIGHT:  return `EV_RIGHT;
      BTN_DOWN:   return `EV_DOWN;
      BTN_ROTATE: return `EV_ROTATE;
      BTN_ENTER:  return `EV_ENTER;
      default:    return `EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/defs.vh
// Game event codes shared by the input front end and main_game_logic.
`ifndef DEFS_VH
`define DEFS_VH
`define EV_NONE   3'd0
`define EV_LEFT   3'd1
`define EV_RIGHT  3'd2
`define EV_DOWN   3'd3
`define EV_ROTATE 3'd4
`define EV_ENTER  3'd5
`endif

// File: rtl/user_event_queue_button_debounce.sv
// button_debounce: 2-FF synchroniser, consecutive-cycle debounce counter and a
// one-cycle pulse on the debounced rising edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any agreement with the current level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_TICKS - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/user_event_queue.sv
// user_event_queue: debounced button presses -> pending bits -> priority arbiter
// -> show-ahead event FIFO. Define USER_EVENT_AUTOREPEAT_EN for L/R/DOWN auto-repeat.
`include "defs.vh"

module user_event_queue
  import user_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned REPEAT_DELAY   = 1024,
  parameter int unsigned REPEAT_PERIOD  = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BTN_CNT-1:0] btn_i,
  output logic [2:0]         user_event_o,
  output logic               user_event_ready_o,
  input  logic               user_event_rd_req_i,
  output logic               overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [BTN_CNT-1:0] level, press, rep, ev;
  logic [BTN_CNT-1:0] pend_q, pend_d, grant;
  logic               overflow_q, overflow_d;
  logic               push, pop, full, empty;
  ev_code_t           push_code;
  ev_code_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_q, rd_q;
  logic [CntW-1:0]    cnt_q, cnt_d;

  for (genvar i = 0; i < BTN_CNT; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_i[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

`ifdef USER_EVENT_AUTOREPEAT_EN
  // LEFT, RIGHT and DOWN occupy the low button indices.
  localparam int unsigned RepCnt  = BTN_DOWN + 1;
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  logic [HoldW-1:0]  hold_q [RepCnt];
  logic [HoldW-1:0]  hold_d [RepCnt];
  logic [RepCnt-1:0] period_q, period_d;

  // hold counts cycles since the press; after the first repeat it restarts at 1
  // and targets REPEAT_PERIOD instead of REPEAT_DELAY.
  always_comb begin
    rep = '0;
    for (int i = 0; i < RepCnt; i++) begin
      hold_d[i]   = '0;
      period_d[i] = 1'b0;
      if (level[i]) begin
        rep[i]      = hold_q[i] == (period_q[i] ? HoldW'(REPEAT_PERIOD) : HoldW'(REPEAT_DELAY));
        hold_d[i]   = rep[i] ? HoldW'(1) : hold_q[i] + 1'b1;
        period_d[i] = period_q[i] | rep[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RepCnt; i++) hold_q[i] <= '0;
      period_q <= '0;
    end else begin
      for (int i = 0; i < RepCnt; i++) hold_q[i] <= hold_d[i];
      period_q <= period_d;
    end
  end

  logic unused_level;
  assign unused_level = ^level[BTN_CNT-1:RepCnt];
`else
  assign rep = '0;

  logic unused_cfg;
  assign unused_cfg = ^{level, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  assign ev    = press | rep;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop   = user_event_rd_req_i & ~empty;

  // A pop frees a slot in the same edge, so a full FIFO can still accept a grant.
  always_comb begin
    grant = '0;
    if (!full || pop) begin
      for (int p = BTN_CNT - 1; p >= 0; p--) begin
        if (pend_q[PRIO_ORDER[p]]) begin
          grant                 = '0;
          grant[PRIO_ORDER[p]]  = 1'b1;
        end
      end
    end
    push      = |grant;
    push_code = `EV_NONE;
    for (int i = 0; i < BTN_CNT; i++) begin
      if (grant[i]) push_code = btn_to_ev(i);
    end
    pend_d     = (pend_q & ~grant) | ev;
    overflow_d = overflow_q | (|(ev & pend_q));
    cnt_d      = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_code;
  end

  assign user_event_o       = empty ? `EV_NONE : mem_q[rd_q];
  assign user_event_ready_o = ~empty;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_user_event_queue.sv
// Bench for user_event_queue: directed scenarios and a randomized run, each edge
// scored against a behavioural model of debounce, pending bits, priority and queue.
module tb_user_event_queue;

  localparam int Ticks   = 4;
  localparam int Depth   = 4;
  localparam int RDelay  = 16;
  localparam int RPeriod = 8;

  localparam logic [2:0] EvNone   = 3'd0;
  localparam logic [2:0] EvLeft   = 3'd1;
  localparam logic [2:0] EvRight  = 3'd2;
  localparam logic [2:0] EvDown   = 3'd3;
  localparam logic [2:0] EvRotate = 3'd4;
  localparam logic [2:0] EvEnter  = 3'd5;

`ifdef USER_EVENT_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] btn_i = '0;
  logic       user_event_rd_req_i = 1'b0;
  logic [2:0] user_event_o;
  logic       user_event_ready_o;
  logic       overflow_o;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Reference model state
  logic [4:0] hist [8];
  logic [4:0] m_lvl, m_pulse, m_pend;
  int         m_hold [5];
  logic [2:0] m_q [$];
  logic       m_ovf;
  int         prio [5] = '{4, 3, 2, 0, 1};

  user_event_queue #(
    .DEBOUNCE_TICKS(Ticks),
    .FIFO_DEPTH    (Depth),
    .REPEAT_DELAY  (RDelay),
    .REPEAT_PERIOD (RPeriod)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .btn_i              (btn_i),
    .user_event_o       (user_event_o),
    .user_event_ready_o (user_event_ready_o),
    .user_event_rd_req_i(user_event_rd_req_i),
    .overflow_o         (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [2:0] code_of(input int idx);
    case (idx)
      0:       return EvLeft;
      1:       return EvRight;
      2:       return EvDown;
      3:       return EvRotate;
      4:       return EvEnter;
      default: return EvNone;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) hist[k] = '0;
    for (int i = 0; i < 5; i++) m_hold[i] = -1;
    m_lvl   = '0;
    m_pulse = '0;
    m_pend  = '0;
    m_ovf   = 1'b0;
    m_q.delete();
  endtask

  // One clock edge: events from the cycle just ended update pending/queue,
  // then the debounced levels advance using the input history.
  task automatic model_edge(input logic [4:0] b, input logic rd);
    logic [4:0] ev;
    logic       pop;
    int         g;
    bit         diff;
    ev = m_pulse;
    for (int i = 0; i < 3; i++) begin
      if (AutoRep && m_hold[i] >= RDelay && (m_hold[i] - RDelay) % RPeriod == 0) ev[i] = 1'b1;
    end
    m_ovf = m_ovf | (|(ev & m_pend));
    pop   = rd && (m_q.size() > 0);
    g     = -1;
    if (m_q.size() < Depth || pop) begin
      for (int k = 0; k < 5; k++) if (g < 0 && m_pend[prio[k]]) g = prio[k];
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(code_of(g));
      m_pend[g] = 1'b0;
    end
    m_pend = m_pend | ev;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = b;
    for (int i = 0; i < 5; i++) begin
      diff = 1'b1;
      for (int k = 2; k <= Ticks + 1; k++) if (hist[k][i] == m_lvl[i]) diff = 1'b0;
      m_pulse[i] = diff && !m_lvl[i];
      if (diff) m_lvl[i] = ~m_lvl[i];
      m_hold[i] = !m_lvl[i] ? -1 : (m_pulse[i] ? 0 : m_hold[i] + 1);
    end
  endtask

  task automatic step(input logic [4:0] b, input logic rd);
    @(negedge clk_i);
    btn_i               = b;
    user_event_rd_req_i = rd;
    @(posedge clk_i);
    model_edge(b, rd);
    #1;
    chk("ready", user_event_ready_o, m_q.size() > 0);
    chk("head", user_event_o, (m_q.size() > 0) ? m_q[0] : EvNone);
    chk("ovf", overflow_o, m_ovf);
  endtask

  initial begin
    int         cnt;
    logic [4:0] rb;
    logic [2:0] seq [4];

    #1 rst_i = 1'b1;
    #2;
    chk("rst_ready", user_event_ready_o, 1'b0);
    chk("rst_head", user_event_o, EvNone);
    chk("rst_ovf", overflow_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    phase = "clean";
    for (int k = 1; k <= 10; k++) begin
      step(5'b01000, 1'b0);
      chk("latency", user_event_ready_o, k >= 8);
    end
    chk("head_rotate", user_event_o, EvRotate);
    step(5'b00000, 1'b1);
    chk("after_pop", user_event_ready_o, 1'b0);
    chk("no_ovf", overflow_o, 1'b0);
    repeat (10) step(5'b00000, 1'b0);

    phase = "bounce";
    for (int k = 1; k <= 12; k++) step(5'(k % 2), 1'b0);
    for (int k = 13; k <= 24; k++) begin
      step(5'b00001, 1'b0);
      chk("latency", user_event_ready_o, k >= 20);
    end
    chk("head_left", user_event_o, EvLeft);
    step(5'b00000, 1'b1);
    repeat (8) step(5'b00000, 1'b0);
    chk("single_event", user_event_ready_o, 1'b0);

    phase = "simul";
    repeat (10) step(5'b11111, 1'b0);
    repeat (2) step(5'b00000, 1'b0);
    chk("full_ready", user_event_ready_o, 1'b1);
    chk("head_enter", user_event_o, EvEnter);
    seq = '{EvRotate, EvDown, EvLeft, EvRight};
    for (int j = 0; j < 4; j++) begin
      step(5'b00000, 1'b1);
      chk("order", user_event_o, seq[j]);
    end
    step(5'b00000, 1'b1);
    chk("drained", user_event_ready_o, 1'b0);
    chk("no_ovf", overflow_o, 1'b0);

    phase = "overflow";
    repeat (10) step(5'b11101, 1'b0);
    repeat (10) step(5'b00000, 1'b0);
    repeat (8) step(5'b00001, 1'b0);
    repeat (8) step(5'b00000, 1'b0);
    chk("pending_no_ovf", overflow_o, 1'b0);
    repeat (8) step(5'b00001, 1'b0);
    chk("ovf_set", overflow_o, 1'b1);
    repeat (8) step(5'b00000, 1'b0);
    cnt = 0;
    repeat (10) begin
      if (user_event_ready_o) cnt++;
      step(5'b00000, 1'b1);
    end
    chk("delivered", cnt, 5);
    chk("ovf_sticky", overflow_o, 1'b1);

    phase = "reset_mid";
    repeat (8) step(5'b11100, 1'b0);
    repeat (4) step(5'b00000, 1'b0);
    chk("queued", user_event_ready_o, 1'b1);
    #2;
    rst_i               = 1'b1;
    btn_i               = '0;
    user_event_rd_req_i = 1'b0;
    #1;
    chk("async_ready", user_event_ready_o, 1'b0);
    chk("async_head", user_event_o, EvNone);
    chk("async_ovf", overflow_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    repeat (20) step(5'b00000, 1'b0);
    chk("quiet", user_event_ready_o, 1'b0);
    repeat (10) step(5'b00010, 1'b0);
    chk("fresh_press", user_event_o, EvRight);
    step(5'b00000, 1'b1);
    chk("fresh_popped", user_event_ready_o, 1'b0);
    repeat (8) step(5'b00000, 1'b0);

    phase = "autorepeat";
    cnt = 0;
    repeat (44) begin
      if (user_event_ready_o) cnt++;
      step(5'b00100, 1'b1);
    end
    repeat (30) begin
      if (user_event_ready_o) cnt++;
      step(5'b00000, 1'b1);
    end
    chk("down_events", cnt, AutoRep ? 5 : 1);
    cnt = 0;
    repeat (44) begin
      if (user_event_ready_o) cnt++;
      step(5'b01000, 1'b1);
    end
    repeat (30) begin
      if (user_event_ready_o) cnt++;
      step(5'b00000, 1'b1);
    end
    chk("rotate_events", cnt, 1);

    phase = "random";
    rb = '0;
    repeat (1500) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      step(rb, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_event_queue.md
Name: user_event_queue

Overview:
- Upstream feeder of main_game_logic.
- Turns five raw player buttons into discrete game events and buffers them in a small FIFO.
- Presents the queue head on the user_event / ready / rd_req handshake that main_game_logic consumes.
- Each button input is synchronised and debounced, and edge-detected. Left, right and down can auto-repeat while held.

Parameters:
- DEBOUNCE_TICKS, 16: consecutive stable cycles required before a debounced level changes (≥1).
- FIFO_DEPTH, 8: event queue depth; power of 2, ≥2.
- REPEAT_DELAY, 1024: cycles a held L/R/DOWN button must stay pressed before the first repeat.
- REPEAT_PERIOD, 256: cycles between subsequent repeats.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- btn_i  in  5  raw buttons, active-high: [0] LEFT, [1] RIGHT, [2] DOWN, [3] ROTATE, [4] ENTER
- user_event_o  out  3  queue head, an `EV_* code from defs.vh
- user_event_ready_o  out  1  queue non-empty, so user_event_o is valid
- user_event_rd_req_i  in  1  consumer pops the head this cycle
- overflow_o  out  1  sticky: at least one event was lost

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Clears sync flops, debounced levels, counters, pending bits, FIFO pointers and overflow.
  - All outputs are 0 during and after reset (user_event_o = 0).
  - Reset mid-operation discards queued events; nothing is emitted until a fresh press.
- Input path (per bit):
  - 2-FF synchroniser, then debounce.
  - The debounced level toggles only after the synchronised value differs from it for DEBOUNCE_TICKS consecutive cycles.
  - The counter restarts on any disagreement glitch.
- Press event: debounced rising edge, pulsed for one cycle.
  - No event on release.
- Code map: LEFT→`EV_LEFT, RIGHT→`EV_RIGHT, DOWN→`EV_DOWN, ROTATE→`EV_ROTATE, ENTER→`EV_ENTER.
- Pending bits (one per button):
  - A press or repeat sets the bit.
  - If the bit is already set, the event is coalesced and overflow_o is set (sticky until reset).
- Arbiter:
  - Each cycle, grants the highest-priority pending bit: ENTER > ROTATE > DOWN > LEFT > RIGHT.
  - Grants only if the FIFO is not full, or a pop happens in the same cycle.
  - A grant pushes the code and clears that pending bit in the same edge.
  - At most one push per cycle.
  - A set and a clear of the same bit in one cycle: the set wins.
- FIFO:
  - Show-ahead: user_event_o shows mem[rd_ptr] combinationally.
  - user_event_ready_o = !empty.
  - user_event_rd_req_i while empty is ignored.
  - Simultaneous push and pop is legal at any fill level, including full; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
  - Consumer contract: ready is held until rd_req; one rd_req per event; ready may remain high for the next entry.
- Latency:
  - Raw edge (stable) to ready rising on an empty queue is exactly DEBOUNCE_TICKS+4 cycles: 2 sync, DEBOUNCE_TICKS debounce, 1 edge/pending, 1 push.
  - Pop to next head visible: same cycle after the edge.

Optional Feature:
- USER_EVENT_AUTOREPEAT_EN defined:
  - LEFT, RIGHT and DOWN each have a hold counter, cleared on release.
  - The first repeat is generated REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles while the button stays held.
  - Repeats go through the pending/overflow logic like presses.
  - ROTATE and ENTER never repeat.
- Undefined: no hold counters are synthesised; exactly one event per press.

Decomposition:
- Shared package user_input_pkg:
  - Button index constants (BTN_LEFT..BTN_ENTER, BTN_CNT=5).
  - Button-to-`EV_* mapping function.
  - Priority order.
- Event codes stay in defs.vh.
- One sub-module, button_debounce: per-bit synchroniser, debounce counter and rising-edge pulse, parameter DEBOUNCE_TICKS.
  - Instantiated BTN_CNT times.
- FIFO, arbiter and repeat logic stay in the top.

Test Plan (bench parameters: DEBOUNCE_TICKS=4, FIFO_DEPTH=4, REPEAT_DELAY=16, REPEAT_PERIOD=8):
- Clean press:
  - Stimulus: btn_i[3] high 10 cycles into an empty queue.
  - Required: ready rises 8 cycles after the edge, head = `EV_ROTATE; one rd_req → ready low; overflow_o=0.
- Bounce:
  - Stimulus: btn_i[0] toggles each cycle for 12 cycles, then stays high.
  - Required: exactly one `EV_LEFT, queued 8 cycles after the last toggle.
- Simultaneous press:
  - Stimulus: btn_i = 5'b11111 on one edge, consumer idle.
  - Required: FIFO fills with ENTER, ROTATE, DOWN, LEFT in that order; RIGHT stays pending.
  - After one pop, RIGHT is pushed the next cycle; overflow_o=0.
- Overflow:
  - Stimulus: with the FIFO full and LEFT pending, press LEFT again (release, re-press).
  - Required: overflow_o=1 and stays 1; the queue still delivers exactly 5 events.
- Autorepeat (macro defined):
  - Stimulus: hold btn_i[2] for 40 cycles after its press event.
  - Required: DOWN events at press, +16, +24, +32, +40; holding ROTATE yields a single event.
  - Macro undefined: a single DOWN.
- Reset mid-operation:
  - Stimulus: assert rst_i asynchronously, between clock edges, with 3 events queued.
  - Required: ready, user_event_o and overflow_o are 0 immediately.
  - After release, no event is produced until a new debounced press.
